// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (async high), MDU_A_i/MDU_B_i operands,
// MDU_op_i/MDU_start_i issue, MDU_hlsel_i read select,
// MDU_busy_o, MDU_HI_o, MDU_LO_o, MDU_HL_o.
// Macro MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7-10).
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDU_A_i,
  input  logic [31:0] MDU_B_i,
  input  logic [3:0]  MDU_op_i,
  input  logic        MDU_start_i,
  input  logic        MDU_hlsel_i,
  output logic        MDU_busy_o,
  output logic [31:0] MDU_HI_o,
  output logic [31:0] MDU_LO_o,
  output logic [31:0] MDU_HL_o
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  logic [31:0] hi, lo;
  logic [31:0] pend_hi, pend_lo;
  logic        busy;
  logic [31:0] cnt;

  logic [31:0] a, b;
  assign a = MDU_A_i;
  assign b = MDU_B_i;

  logic [63:0] smul, umul;
  assign smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign umul = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so that the
  // 0x80000000 / -1 case wraps to 0x80000000, rem 0.
  logic [31:0] ma, mb, mq, mr;
  logic [31:0] uq, ur, sq, sr;
  logic        bz;
  assign bz = (b == 32'd0);
  assign ma = a[31] ? -a : a;
  assign mb = b[31] ? -b : b;
  assign mq = bz ? 32'd0 : ma / mb;
  assign mr = bz ? 32'd0 : ma % mb;
  assign uq = bz ? 32'hFFFF_FFFF : a / b;
  assign ur = bz ? a : a % b;
  assign sq = bz ? 32'hFFFF_FFFF
            : (a[31] ^ b[31]) ? -mq : mq;
  assign sr = bz ? a : (a[31] ? -mr : mr);

  logic [63:0] res;
  logic        run;
  logic [31:0] len;
  logic        set_hi, set_lo;

  always_comb begin
    res    = {hi, lo};
    run    = 1'b0;
    len    = 32'd0;
    set_hi = 1'b0;
    set_lo = 1'b0;
    case (MDU_op_i)
      OP_MULT: begin
        res = smul; run = 1'b1; len = 32'(MULT_CYCLES);
      end
      OP_MULTU: begin
        res = umul; run = 1'b1; len = 32'(MULT_CYCLES);
      end
      OP_DIV: begin
        res = {sr, sq}; run = 1'b1; len = 32'(DIV_CYCLES);
      end
      OP_DIVU: begin
        res = {ur, uq}; run = 1'b1; len = 32'(DIV_CYCLES);
      end
      OP_MTHI: set_hi = 1'b1;
      OP_MTLO: set_lo = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD: begin
        res = {hi, lo} + smul; run = 1'b1;
        len = 32'(MULT_CYCLES);
      end
      OP_MADDU: begin
        res = {hi, lo} + umul; run = 1'b1;
        len = 32'(MULT_CYCLES);
      end
      OP_MSUB: begin
        res = {hi, lo} - smul; run = 1'b1;
        len = 32'(MULT_CYCLES);
      end
      OP_MSUBU: begin
        res = {hi, lo} - umul; run = 1'b1;
        len = 32'(MULT_CYCLES);
      end
`endif
      default: ;
    endcase
  end

  // While busy every start is dropped, including one that
  // lands on the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      busy    <= 1'b0;
      cnt     <= 32'd0;
    end else if (busy) begin
      cnt <= cnt - 32'd1;
      if (cnt == 32'd1) begin
        hi   <= pend_hi;
        lo   <= pend_lo;
        busy <= 1'b0;
      end
    end else if (MDU_start_i) begin
      if (run) begin
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        busy    <= 1'b1;
        cnt     <= len;
      end
      if (set_hi) hi <= a;
      if (set_lo) lo <= a;
    end
  end

  assign MDU_busy_o = busy;
  assign MDU_HI_o   = hi;
  assign MDU_LO_o   = lo;
  assign MDU_HL_o   = MDU_hlsel_i ? hi : lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed vector bench for mdu_hilo.
// Table of ops with expected HI/LO/latency plus corner sequences.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        start;
  logic        hlsel;
  logic        busy;
  logic [31:0] hi_o, lo_o, hl_o;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .MDU_A_i     (a),
    .MDU_B_i     (b),
    .MDU_op_i    (op),
    .MDU_start_i (start),
    .MDU_hlsel_i (hlsel),
    .MDU_busy_o  (busy),
    .MDU_HI_o    (hi_o),
    .MDU_LO_o    (lo_o),
    .MDU_HL_o    (hl_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs [18];
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] o,
                         input logic [31:0] va, vb, eh, el,
                         input int c);
    vecs[i].op  = o;
    vecs[i].a   = va;
    vecs[i].b   = vb;
    vecs[i].hi  = eh;
    vecs[i].lo  = el;
    vecs[i].cyc = c;
  endtask

  // Pulse start for one cycle; returns at the negedge after
  // the start edge.
  task automatic issue(input logic [3:0] o,
                       input logic [31:0] va, vb);
    op = o; a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  logic [31:0] cur_hi, cur_lo;
  int cyc;

  initial begin
    set_vec(0,  4'd5, 32'h12345678, 32'h0,
            32'h12345678, 32'h0, 0);
    set_vec(1,  4'd1, 32'hFFFFFFFE, 32'd3,
            32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    set_vec(2,  4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001, 5);
    set_vec(3,  4'd3, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    set_vec(4,  4'd4, 32'd7, 32'd0,
            32'd7, 32'hFFFFFFFF, 10);
    set_vec(5,  4'd3, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000, 10);
    set_vec(6,  4'd3, 32'd7, 32'hFFFFFFFE,
            32'd1, 32'hFFFFFFFD, 10);
    set_vec(7,  4'd3, 32'hFFFFFFF9, 32'd0,
            32'hFFFFFFF9, 32'hFFFFFFFF, 10);
    set_vec(8,  4'd4, 32'd100, 32'd7,
            32'd2, 32'd14, 10);
    set_vec(9,  4'd6, 32'hA5A5A5A5, 32'h0,
            32'd2, 32'hA5A5A5A5, 0);
    set_vec(10, 4'd0, 32'hDEADBEEF, 32'd1,
            32'd2, 32'hA5A5A5A5, 0);
    set_vec(11, 4'd15, 32'hDEADBEEF, 32'd1,
            32'd2, 32'hA5A5A5A5, 0);
    set_vec(12, 4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF,
            32'h3FFFFFFF, 32'h00000001, 5);
    set_vec(13, 4'd5, 32'h0, 32'h0,
            32'h0, 32'h00000001, 0);
    set_vec(14, 4'd6, 32'hFFFFFFFF, 32'h0,
            32'h0, 32'hFFFFFFFF, 0);
`ifdef MDU_MADD_EN
    set_vec(15, 4'd8, 32'd1, 32'd1,
            32'd1, 32'h0, 5);
    set_vec(16, 4'd9, 32'd2, 32'd3,
            32'h0, 32'hFFFFFFFA, 5);
    set_vec(17, 4'd7, 32'hFFFFFFFF, 32'd6,
            32'h0, 32'hFFFFFFF4, 5);
`else
    set_vec(15, 4'd8, 32'd1, 32'd1,
            32'h0, 32'hFFFFFFFF, 0);
    set_vec(16, 4'd9, 32'd2, 32'd3,
            32'h0, 32'hFFFFFFFF, 0);
    set_vec(17, 4'd7, 32'hFFFFFFFF, 32'd6,
            32'h0, 32'hFFFFFFFF, 0);
`endif

    reset = 1'b1; a = '0; b = '0; op = '0;
    start = 1'b0; hlsel = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    cur_hi = 32'h0;
    cur_lo = 32'h0;

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      cyc = 0;
      while (busy && cyc < 40) begin
        cyc++;
        if (cyc == 1) begin
          check($sformatf("v%0d_old_hi", i), hi_o, cur_hi);
          check($sformatf("v%0d_old_lo", i), lo_o, cur_lo);
        end
        @(negedge clk);
      end
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      check($sformatf("v%0d_hi", i), hi_o, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo_o, vecs[i].lo);
      hlsel = 1'b1; #1;
      check($sformatf("v%0d_hl1", i), hl_o, vecs[i].hi);
      hlsel = 1'b0; #1;
      check($sformatf("v%0d_hl0", i), hl_o, vecs[i].lo);
      cur_hi = vecs[i].hi;
      cur_lo = vecs[i].lo;
    end

    // start on the commit edge is dropped
    issue(4'd1, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    check("commit_busy", {31'd0, busy}, 32'd1);
    op = 4'd6; a = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("commit_busy_fall", {31'd0, busy}, 32'd0);
    check("commit_hi", hi_o, 32'h0);
    check("commit_lo", lo_o, 32'd6);
    @(negedge clk);
    check("commit_no_late", lo_o, 32'd6);

    // starts during busy ignored, then reset mid-op
    issue(4'd4, 32'd100, 32'd7);
    issue(4'd6, 32'd5, 32'd0);
    issue(4'd1, 32'd9, 32'd9);
    check("ign_busy", {31'd0, busy}, 32'd1);
    check("ign_lo", lo_o, 32'd6);
    check("ign_hi", hi_o, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    check("rst_nocommit_hi", hi_o, 32'h0);
    check("rst_nocommit_lo", lo_o, 32'h0);
    check("rst_nocommit_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
